// File: rtl/pc_unit_pkg.sv
// Shared opcode constants and decode record for the program-counter unit.
package pc_unit_pkg;

  localparam int PC_W = 16;
  localparam int OP_W = 3;

  // Opcodes; bit 0 of the [0:2] opcode is the MSB.
  localparam logic [0:OP_W-1] OP_HOLD = 3'b000;
  localparam logic [0:OP_W-1] OP_INC  = 3'b001;
  localparam logic [0:OP_W-1] OP_DEC  = 3'b010;
  localparam logic [0:OP_W-1] OP_JMP  = 3'b011;
  localparam logic [0:OP_W-1] OP_CALL = 3'b100;
  localparam logic [0:OP_W-1] OP_RET  = 3'b101;

  // Per-cycle decode result that drives the state updates.
  typedef struct packed {
    logic push;
    logic pop;
    logic err;
  } dec_t;

endpackage

// File: rtl/pc_unit_incrementer.sv
// 16-bit +1/-1 step unit; wraps modulo 2^16 in both directions.
module incrementer
  import pc_unit_pkg::*;
(
  input  logic [0:PC_W-1] i_a,
  input  logic            i_dir,
  output logic [0:PC_W-1] o_y
);

  // i_dir=1 steps up, i_dir=0 steps down
  always_comb begin
    o_y = i_dir ? (i_a + 16'd1) : (i_a - 16'd1);
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with return-address stack, sticky error flag and
// single-cycle registered update.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [0:PC_W-1] RESET_PC = 16'h0000,
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [0:OP_W-1] i_op,
  input  logic [0:PC_W-1] i_target,
  output logic [0:PC_W-1] o_pc,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_err
);

  // Pointer index width; the count carries one extra bit so DEPTH fits.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [0:PC_W-1] r_pc;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [0:PC_W-1] r_stk [DEPTH];

  logic            w_dir;
  logic [0:PC_W-1] w_step;
  logic [0:PC_W-1] w_top;
  logic [PW-1:0]   w_top_idx;
  logic [0:PC_W-1] w_pc_nxt;
  logic            w_full;
  logic            w_empty;
  dec_t            w_dec;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Step down only for DEC; CALL thereby gets pc+1 as its return address.
  assign w_dir = (i_op != OP_DEC);

  incrementer u_inc (
    .i_a   (r_pc),
    .i_dir (w_dir),
    .o_y   (w_step)
  );

  // Top-of-stack is entry cnt-1; low-bit arithmetic handles cnt==DEPTH.
  assign w_top_idx = r_cnt[PW-1:0] - PW'(1);
  assign w_top     = r_stk[w_top_idx];

  // Opcode decode: next pc plus push/pop/error strobes; i_en gates everything.
  always_comb begin
    w_pc_nxt = r_pc;
    w_dec    = '0;
    if (i_en) begin
      case (i_op)
        OP_HOLD: ;
        OP_INC,
        OP_DEC:  w_pc_nxt = w_step;
        OP_JMP:  w_pc_nxt = i_target;
        OP_CALL: begin
          if (w_full) begin
            w_dec.err = 1'b1;
          end else begin
            w_dec.push = 1'b1;
            w_pc_nxt   = i_target;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_dec.err = 1'b1;
          end else begin
            w_dec.pop = 1'b1;
            w_pc_nxt  = w_top;
          end
        end
        default: w_dec.err = 1'b1;
      endcase
    end
  end

  // Stack storage; not cleared on reset, entries above occupancy are don't-care.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_dec.push) begin
      r_stk[r_cnt[PW-1:0]] <= w_step;
    end
  end

  // PC, occupancy and sticky error; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc  <= RESET_PC;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_dec.push) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_dec.pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_dec.err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_pc    = r_pc;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_err   = r_err;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the program counter value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 4, the number of return-address stack entries (power of two, 2..16).
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset; synchronous and active-high.
REQ-005 i_en  input  1  operation enable; when low, i_op is ignored and all state holds.
REQ-006 i_op  input  [0:2]  operation code; bit 0 is the MSB.
REQ-007 i_target  input  [0:15]  jump/call destination; bit 0 is the MSB.
REQ-008 o_pc  output  [0:15]  current program counter, registered.
REQ-009 o_full  output  1  high when the stack holds DEPTH entries.
REQ-010 o_empty  output  1  high when the stack holds 0 entries.
REQ-011 o_err  output  1  sticky error flag, registered.

Function
REQ-012 SHALL sample i_op and i_target on a rising edge with i_en=1; the resulting o_pc SHALL be visible after that same edge (1-cycle latency, no combinational path from inputs to o_pc).
REQ-013 Opcodes: 000 HOLD, 001 INC, 010 DEC, 011 JMP, 100 CALL, 101 RET, 110/111 reserved.
REQ-014 HOLD: o_pc and stack unchanged.
REQ-015 INC: o_pc <= o_pc+1 modulo 2^16; 16'hFFFF wraps to 16'h0000 with no error.
REQ-016 DEC: o_pc <= o_pc-1 modulo 2^16; 16'h0000 wraps to 16'hFFFF with no error.
REQ-017 JMP: o_pc <= i_target; stack unchanged.
REQ-018 CALL when not full: push (o_pc+1 mod 2^16) onto the stack; o_pc <= i_target; occupancy +1.
REQ-019 CALL when full: no push; o_pc unchanged; o_err set.
REQ-020 RET when not empty: o_pc <= top of stack; occupancy -1.
REQ-021 RET when empty: o_pc unchanged; o_err set.
REQ-022 Reserved opcode with i_en=1: behaves as HOLD and sets o_err.
REQ-023 o_err SHALL stay set until reset; subsequent valid operations SHALL execute normally while o_err is high.
REQ-024 The stack is LIFO; the stack pointer SHALL never wrap, and entries above occupancy are don't-care.
REQ-025 o_full and o_empty SHALL be derived from the registered occupancy count and SHALL update on the same edge as the push or pop.
REQ-026 A CALL at o_pc=16'hFFFF SHALL push 16'h0000.

Reset
REQ-027 On a rising edge with i_rst=1: o_pc <= RESET_PC, occupancy <= 0 (o_empty=1, o_full=0), o_err <= 0.
REQ-028 i_rst SHALL take priority over i_en and i_op, including mid-sequence (e.g. between a CALL and a RET).
REQ-029 Stack storage contents need not be cleared on reset.

Structure
REQ-030 Opcode constants (OP_HOLD..OP_RET) SHALL live in a shared package used by the decoder and the bench.
REQ-031 The +1/-1 arithmetic SHALL instantiate the existing 16-bit incrementer sub-module (named incrementer): i_dir=1 yields +1 and i_dir=0 yields -1; the CALL return address uses the +1 result.
REQ-032 All other logic (opcode decode, stack array, pointer, flags) SHALL be in pc_unit.

Verification
REQ-033 Reset, then 3x INC -> o_pc 0x0000, 0x0001, 0x0002, 0x0003 on successive edges; o_empty=1, o_err=0.
REQ-034 JMP 0xFFFF, INC, DEC, DEC -> o_pc 0xFFFF, 0x0000, 0xFFFF, 0xFFFE; o_err=0.
REQ-035 With o_pc=0x0010: CALL 0x0100, CALL 0x0200, RET, RET -> o_pc 0x0100, 0x0200, 0x0101, 0x0011; o_empty returns to 1.
REQ-036 With DEPTH=4: five CALLs -> o_full=1 after the 4th; the 5th leaves o_pc unchanged and sets o_err; four RETs then unwind correctly.
REQ-037 RET on an empty stack, then op 111 -> o_pc unchanged and o_err=1 after the first; INC still advances; assert i_rst -> o_pc=RESET_PC, o_err=0.
REQ-038 With i_en=0 and i_op=CALL for 3 cycles -> no change to o_pc, occupancy or o_err.
